// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: single-clock AHB-Lite slave to APB4 master bridge.
// Exactly one transfer is in flight at a time. Each accepted AHB transfer
// runs one APB SETUP/ACCESS sequence. Read data and the response are
// returned through registered outputs.
//
// Optional feature macro: AHB2APB_SLVERR_EN
//   defined   - pslverr is returned as a two-cycle AHB ERROR response
//   undefined - pslverr is ignored and every completion is OKAY
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | no APB transfer; AHB data phase (if any) completes here
//   ST_SETUP  | APB setup phase (psel=1, penable=0)
//   ST_ACCESS | APB access phase (psel=1, penable=1), waits for pready
//   ST_ERR    | first AHB error cycle (hresp=1, hreadyout=0)
module ahb2apb_bridge #(
  parameter  int AWIDTH = 10,
  parameter  int DSIZE  = 2,
  localparam int DBYTES = 1 << DSIZE,
  localparam int DWIDTH = DBYTES * 8
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic              hready,
  input  logic              hwrite,
  input  logic              hmastlock,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hburst,
  input  logic [2:0]        hsize,
  input  logic [3:0]        hprot,
  input  logic [AWIDTH-1:0] haddr,
  input  logic [DWIDTH-1:0] hwdata,
  output logic [DWIDTH-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [2:0]        pprot,
  output logic [AWIDTH-1:0] paddr,
  output logic [DBYTES-1:0] pstrb,
  output logic [DWIDTH-1:0] pwdata,
  input  logic [DWIDTH-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DWIDTH-1:0]   r_hrdata;
  logic                r_hreadyout;
  logic                r_hresp;
  logic                r_pwrite;
  logic [2:0]          r_pprot;
  logic [AWIDTH-1:0]   r_paddr;
  logic [DBYTES-1:0]   r_pstrb;

  logic                w_capture;
  logic                w_err;
  logic [DSIZE-1:0]    w_szmask;
  logic [DBYTES-1:0]   w_pstrb_nxt;
  logic                w_unused;

  // Only IDLE can accept a new address phase; hreadyout is high only there.
  assign w_capture = (r_state == ST_IDLE) & hsel & hready & htrans[1];

`ifdef AHB2APB_SLVERR_EN
  assign w_err = pslverr;
`else
  assign w_err = 1'b0;
`endif

  // Transfer type bit 0, burst, lock and the cache/buffer prot bits play no role.
  assign w_unused = ^{htrans[0], hburst, hmastlock, hprot[3:2], pslverr};

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_capture) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (pready) w_state_nxt = w_err ? ST_ERR : ST_IDLE;
      ST_ERR:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Byte strobes: a lane is enabled when it falls inside the size-aligned
  // block containing haddr. Sizes at or above the bus width enable every lane.
  always_comb begin
    w_szmask    = '0;
    w_pstrb_nxt = '0;
    for (int b = 0; b < DSIZE; b++) w_szmask[b] = (hsize > 3'(b));
    if (hwrite) begin
      for (int i = 0; i < DBYTES; i++)
        w_pstrb_nxt[i] = ((DSIZE'(i) & ~w_szmask) == (haddr[DSIZE-1:0] & ~w_szmask));
    end
  end

  // APB address/control, captured from the AHB address phase.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pprot  <= '0;
      r_pstrb  <= '0;
    end else if (w_capture) begin
      r_paddr  <= haddr;
      r_pwrite <= hwrite;
      r_pprot  <= {~hprot[0], 1'b0, hprot[1]};
      r_pstrb  <= w_pstrb_nxt;
    end
  end

  // AHB response registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_hrdata    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hresp <= 1'b0;
          if (w_capture) r_hreadyout <= 1'b0;
        end
        ST_ACCESS: begin
          if (pready) begin
            if (w_err) begin
              r_hresp <= 1'b1;
            end else begin
              r_hreadyout <= 1'b1;
              if (!r_pwrite) r_hrdata <= prdata;
            end
          end
        end
        ST_ERR:  r_hreadyout <= 1'b1;
        default: ;
      endcase
    end
  end

  assign psel      = (r_state == ST_SETUP) | (r_state == ST_ACCESS);
  assign penable   = (r_state == ST_ACCESS);
  assign pwrite    = r_pwrite;
  assign pprot     = r_pprot;
  assign paddr     = r_paddr;
  assign pstrb     = r_pstrb;
  assign pwdata    = hwdata;
  assign hrdata    = r_hrdata;
  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Scoreboard bench for ahb2apb_bridge: a driver issues directed and random
// AHB transfers and pushes expectations; an APB responder plays the target;
// separate APB and AHB monitors pop and compare.
module tb_ahb2apb_bridge;
  localparam int AW = 10;
  localparam int DS = 2;
  localparam int DB = 4;
  localparam int DW = 32;

`ifdef AHB2APB_SLVERR_EN
  localparam bit SLVERR_ON = 1'b1;
`else
  localparam bit SLVERR_ON = 1'b0;
`endif

  logic          hclk = 1'b0;
  logic          hresetn = 1'b0;
  logic          hsel, hwrite, hmastlock;
  logic [1:0]    htrans;
  logic [2:0]    hburst, hsize;
  logic [3:0]    hprot;
  logic [AW-1:0] haddr;
  logic [DW-1:0] hwdata, hrdata, pwdata, prdata;
  logic          hreadyout, hresp, psel, penable, pwrite, pready, pslverr;
  logic [2:0]    pprot;
  logic [AW-1:0] paddr;
  logic [DB-1:0] pstrb;

  ahb2apb_bridge #(.AWIDTH(AW), .DSIZE(DS)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .hready(hreadyout),
    .hwrite(hwrite), .hmastlock(hmastlock), .htrans(htrans), .hburst(hburst),
    .hsize(hsize), .hprot(hprot), .haddr(haddr), .hwdata(hwdata),
    .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pprot(pprot), .paddr(paddr),
    .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [3:0]    prot;
    logic [DW-1:0] wdata;
    int            waits;
    logic [DW-1:0] rdata;
    logic          err;
  } txn_t;
  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DB-1:0] strb;
    logic [2:0]    prot;
    logic [DW-1:0] wdata;
  } apb_exp_t;
  typedef struct {
    logic          rd;
    logic [DW-1:0] rdata;
    logic          resp;
    int            low;
  } ahb_exp_t;
  typedef struct {
    int            waits;
    logic [DW-1:0] rdata;
    logic          err;
  } rsp_t;

  apb_exp_t apb_q[$];
  ahb_exp_t ahb_q[$];
  rsp_t     rsp_q[$];

  int            n_checks = 0;
  int            n_fail = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] next_hwdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte lanes written: 2^size bytes starting at the address aligned down to
  // the transfer size; full-width or wider sizes write every lane.
  function automatic logic [DB-1:0] model_strb(input logic wr, input logic [AW-1:0] a,
                                               input logic [2:0] sz);
    int nb, off;
    if (!wr) return '0;
    if (int'(sz) >= DS) return '1;
    nb  = 1 << int'(sz);
    off = ((int'(a) % DB) / nb) * nb;
    return DB'(((1 << nb) - 1) << off);
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.wr    = 1'($urandom % 2);
    t.addr  = AW'($urandom);
    t.size  = 3'($urandom_range(0, 3));
    t.prot  = 4'($urandom);
    t.wdata = $urandom;
    t.waits = $urandom_range(0, 3);
    t.rdata = $urandom;
    t.err   = ($urandom % 4) == 0;
    return t;
  endfunction

  // Wait for the edge that accepts the current address phase (hready high).
  task automatic wait_capture();
    int n = 0;
    @(negedge hclk);
    while (!hreadyout && n < 100) begin
      @(negedge hclk);
      n++;
    end
    if (!hreadyout) begin
      $display("FAIL capture_timeout: hreadyout stuck at %0b, expected 1", hreadyout);
      $fatal(1, "bench stopped");
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic issue(input txn_t t, input logic [1:0] tr, input logic sel);
    logic e;
    hsel      = sel;
    htrans    = tr;
    haddr     = t.addr;
    hwrite    = t.wr;
    hsize     = t.size;
    hprot     = t.prot;
    hburst    = 3'($urandom);
    hmastlock = 1'($urandom);
    hwdata    = next_hwdata;
    if (sel && tr[1]) begin
      e = t.err && SLVERR_ON;
      apb_q.push_back('{t.addr, t.wr, model_strb(t.wr, t.addr, t.size),
                        {~t.prot[0], 1'b0, t.prot[1]}, t.wdata});
      ahb_q.push_back('{!t.wr, t.rdata, e, 2 + t.waits + (e ? 1 : 0)});
      rsp_q.push_back('{t.waits, t.rdata, t.err});
    end
    wait_capture();
    next_hwdata = (sel && tr[1] && t.wr) ? t.wdata : DW'($urandom);
  endtask

  // APB target: pready held low for the scheduled wait count, junk elsewhere.
  initial begin
    int   cnt;
    rsp_t r;
    cnt = 0;
    r = '{0, '0, 1'b0};
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    forever begin
      @(posedge hclk);
      #1;
      if (!hresetn) begin
        pready = 1'b0; cnt = 0;
      end else if (psel && !penable) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_q_empty", 32'(rsp_q.size()), 32'd1);
          r = '{0, '0, 1'b0};
        end else begin
          r = rsp_q.pop_front();
        end
        cnt = r.waits; pready = 1'b0; pslverr = 1'($urandom);
      end else if (psel && penable) begin
        if (cnt == 0) begin
          pready = 1'b1; prdata = r.rdata; pslverr = r.err;
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom); cnt--;
        end
      end else begin
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      end
    end
  end

  // APB monitor: setup and every access cycle must present the expected transfer.
  always @(negedge hclk) begin
    apb_exp_t e;
    if (mon_en && psel) begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected", 32'(apb_q.size()), 32'd1);
      end else begin
        e = apb_q[0];
        chk("paddr", 32'(paddr), 32'(e.addr));
        if (penable) begin
          chk("pwrite", 32'(pwrite), 32'(e.wr));
          chk("pstrb", 32'(pstrb), 32'(e.strb));
          chk("pprot", 32'(pprot), 32'(e.prot));
          if (e.wr) chk("pwdata", pwdata, e.wdata);
          if (pready) void'(apb_q.pop_front());
        end
      end
    end
  end

  // AHB monitor: counts wait cycles and checks each completed data phase.
  int   low_cnt = 0;
  logic prev_hresp = 1'b0;
  always @(negedge hclk) begin
    ahb_exp_t e;
    if (mon_en) begin
      if (hreadyout) begin
        if (low_cnt > 0) begin
          if (ahb_q.size() == 0) begin
            chk("ahb_unexpected", 32'(ahb_q.size()), 32'd1);
          end else begin
            e = ahb_q.pop_front();
            chk("wait_cycles", 32'(low_cnt), 32'(e.low));
            chk("hresp", 32'(hresp), 32'(e.resp));
            chk("hresp_prev", 32'(prev_hresp), 32'(e.resp));
            if (e.rd && !e.resp) chk("hrdata", hrdata, e.rdata);
          end
        end else begin
          chk("idle_okay", 32'(hresp), 32'd0);
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      prev_hresp = hresp;
    end
  end

  initial begin
    txn_t t;
    int   n;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hmastlock = 1'b0; hburst = '0;
    hsize = '0; hprot = '0; haddr = '0; hwdata = '0;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("rst_hresp", 32'(hresp), 32'd0);
    chk("rst_hrdata", hrdata, 32'd0);
    chk("rst_psel_penable", 32'({psel, penable}), 32'd0);
    chk("rst_pwrite", 32'(pwrite), 32'd0);
    chk("rst_paddr", 32'(paddr), 32'd0);
    chk("rst_pstrb", 32'(pstrb), 32'd0);
    chk("rst_pprot", 32'(pprot), 32'd0);
    @(negedge hclk);
    hresetn = 1'b1;
    mon_en = 1'b1;
    @(posedge hclk);
    #1;

    // Directed: word write, byte write, read with 3 wait states,
    // back-to-back write/read, a slave error, then an error followed directly.
    issue('{1'b1, 10'h010, 3'd2, 4'h3, 32'hDEADBEEF, 0, 32'h0, 1'b0}, 2'b10, 1'b1);
    issue('{1'b1, 10'h013, 3'd0, 4'h1, 32'hA5A5A5A5, 0, 32'h0, 1'b0}, 2'b10, 1'b1);
    issue('{1'b0, 10'h010, 3'd2, 4'h2, 32'h0, 3, 32'h12345678, 1'b0}, 2'b10, 1'b1);
    issue('{1'b1, 10'h000, 3'd2, 4'h0, 32'h01020304, 0, 32'h0, 1'b0}, 2'b10, 1'b1);
    issue('{1'b0, 10'h004, 3'd2, 4'h1, 32'h0, 0, 32'hCAFEF00D, 1'b0}, 2'b10, 1'b1);
    issue('{1'b0, 10'h020, 3'd2, 4'h1, 32'h0, 1, 32'h55AA55AA, 1'b1}, 2'b10, 1'b1);
    issue('{1'b1, 10'h022, 3'd1, 4'h1, 32'h11223344, 0, 32'h0, 1'b0}, 2'b11, 1'b1);

    for (int i = 0; i < 120; i++) begin
      t = rnd_txn();
      case ($urandom % 5)
        0:       issue(t, 2'($urandom % 2), 1'($urandom));
        1:       issue(t, 2'b10, 1'b0);
        default: issue(t, 2'b10 | 2'($urandom % 2), 1'b1);
      endcase
    end
    t = rnd_txn();
    issue(t, 2'b00, 1'b0);
    n = 0;
    while ((apb_q.size() != 0 || ahb_q.size() != 0) && n < 200) begin
      @(posedge hclk);
      n++;
    end
    #1;
    chk("apb_q_drained", 32'(apb_q.size()), 32'd0);
    chk("ahb_q_drained", 32'(ahb_q.size()), 32'd0);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

    // Reset in the middle of ACCESS: everything returns to reset values at once.
    mon_en = 1'b0;
    issue('{1'b0, 10'h100, 3'd2, 4'h0, 32'h0, 6, 32'h87654321, 1'b0}, 2'b10, 1'b1);
    hsel = 1'b0; htrans = 2'b00;
    n = 0;
    @(negedge hclk);
    while (!(psel && penable) && n < 10) begin
      @(negedge hclk);
      n++;
    end
    chk("reached_access", 32'({psel, penable}), 32'd3);
    #2 hresetn = 1'b0;
    #1;
    chk("mid_rst_psel", 32'(psel), 32'd0);
    chk("mid_rst_penable", 32'(penable), 32'd0);
    chk("mid_rst_hreadyout", 32'(hreadyout), 32'd1);
    chk("mid_rst_hresp", 32'(hresp), 32'd0);
    chk("mid_rst_paddr", 32'(paddr), 32'd0);
    apb_q.delete(); ahb_q.delete(); rsp_q.delete();
    #1 hresetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      htrans = 2'($urandom % 2);
      hsel = 1'b1;
      @(negedge hclk);
      chk("post_rst_hreadyout", 32'(hreadyout), 32'd1);
      chk("post_rst_psel", 32'(psel), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: time %0t, expected finish earlier", $time);
    $fatal(1, "bench stopped");
  end

endmodule

// File: doc/ahb2apb_bridge.md
# ahb2apb_bridge

Single-clock AHB-Lite slave to APB4 master bridge, one outstanding transfer. It sits directly upstream of `apb_ram` in the simulation RAM harness, so one AHB master can exercise the APB target. Each accepted AHB transfer becomes one APB SETUP/ACCESS sequence. Read data and slave errors are returned to the AHB side through registered outputs.

## Interface
- `AWIDTH`, 10: address width, bits, both sides.
- `DSIZE`, 2: data size is 2^DSIZE bytes.
- `DBYTES`, 1<<DSIZE: derived, data bytes.
- `DWIDTH`, DBYTES*8: derived, data width in bits.

Ports:
- `hclk` in 1: single clock for the AHB and APB sides (PCLK = HCLK).
- `hresetn` in 1: reset, asynchronous, active-low.
- `hsel`, `hready`, `hwrite`, `hmastlock` in 1: AHB-Lite slave inputs.
- `htrans` in 2; `hburst` in 3; `hsize` in 3; `hprot` in 4: AHB-Lite slave inputs.
- `haddr` in AWIDTH; `hwdata` in DWIDTH: AHB-Lite slave inputs.
- `hrdata` out DWIDTH: registered read data.
- `hreadyout` out 1: registered ready.
- `hresp` out 1: registered response, 1 = ERROR.
- `psel`, `penable`, `pwrite` out 1: APB master outputs.
- `pprot` out 3; `paddr` out AWIDTH; `pstrb` out DBYTES; `pwdata` out DWIDTH: APB master outputs.
- `prdata` in DWIDTH; `pready` in 1; `pslverr` in 1: APB completer inputs.

## Operation
- Capture condition: `hsel & hready & htrans[1]`. NONSEQ and SEQ are treated the same. IDLE, BUSY, `hburst` and `hmastlock` are ignored, and IDLE/BUSY get zero-wait OKAY.
- On capture, register:
  - `paddr` = `haddr`
  - `pwrite` = `hwrite`
  - `pprot` = {~hprot[0], 1'b0, hprot[1]}
  - `pstrb` (see below)
- `pstrb`:
  - Reads: 0.
  - Writes: mask of 2^hsize ones, shifted to `haddr[DSIZE-1:0]` aligned down to the transfer size.
  - `hsize` >= DSIZE: all ones.
- `pwdata` = `hwdata` combinationally. `hwdata` is stable for the whole AHB data phase because `hreadyout` is held low.
- FSM states: IDLE, SETUP, ACCESS, ERR.
  - IDLE: on capture, go to SETUP and set `hreadyout`<=0, `hresp`<=0.
  - SETUP: `psel`=1, `penable`=0. Go to ACCESS unconditionally.
  - ACCESS: `psel`=1, `penable`=1. Stay while `pready`=0.
    - `pready & ~pslverr`: `hrdata`<=`prdata` (reads only), `hreadyout`<=1, go to IDLE.
    - `pready & pslverr`: `hresp`<=1, `hreadyout` stays 0, go to ERR.
  - ERR: `hreadyout`<=1, `hresp` stays 1, go to IDLE. This is the second cycle of the two-cycle AHB error response.
- In IDLE, `hresp`<=0 on every edge that does not capture.
- The cycle in which `hreadyout`=1 completes the data phase and may itself carry a new address phase. That includes the second error cycle, and a capture there is legal. Capture then proceeds as above with no gap.
- `psel`/`penable` are decoded from the state. Other APB outputs hold their last captured value while idle.

## Timing
- Reset values:
  - FSM IDLE.
  - `hreadyout`=1, `hresp`=0, `hrdata`=0.
  - `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pstrb`=0, `pprot`=0.
- Zero-wait APB transfer, captured at edge 0:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - `hreadyout`=1 in cycle 3 with read data valid.
  - AHB sees 2 wait states. Back-to-back throughput is one transfer per 3 cycles.
- Each APB wait state (`pready`=0 in ACCESS) adds one AHB wait state.
- Error path: ACCESS, then (`hresp`=1, `hreadyout`=0), then (`hresp`=1, `hreadyout`=1).
- Asserting `hresetn` mid-transfer forces all reset values immediately, asynchronously. The APB transfer is abandoned and no completion is reported.

## Configuration
- `AHB2APB_SLVERR_EN`:
  - Defined: `pslverr` is propagated as the two-cycle AHB ERROR response described above.
  - Undefined: `pslverr` is ignored, every completion is OKAY, and the ERR state is never entered.

## Test plan
All scenarios use DSIZE=2, AWIDTH=10.
- Word write: `haddr`=0x010, `hsize`=2, `hwdata`=0xDEADBEEF, `pready`=1 → cycle 1 `psel`=1 `penable`=0; cycle 2 `penable`=1, `pwrite`=1, `paddr`=0x010, `pstrb`=4'hF, `pwdata`=0xDEADBEEF; cycle 3 `hreadyout`=1, `hresp`=0.
- Byte write then read: write `haddr`=0x013, `hsize`=0 → `pstrb`=4'b1000. Read 0x010 with `prdata`=0x12345678 → `hrdata`=0x12345678 when `hreadyout` rises; read `pstrb`=0.
- Wait states: read with `pready` low for 3 ACCESS cycles → `hreadyout` low 5 cycles total, `psel`/`penable` held, `paddr` stable.
- Slave error (macro defined): `pslverr`=1 with `pready` → `hresp`=1/`hreadyout`=0, then `hresp`=1/`hreadyout`=1, then IDLE with `hresp`=0. Macro undefined: OKAY completion.
- Back-to-back: write 0x000, new NONSEQ read 0x004 presented in the completing cycle → second SETUP in the next cycle, no idle gap.
- Reset mid-ACCESS: drop `hresetn` → same cycle `psel`=0, `penable`=0, `hreadyout`=1. After release, an IDLE `htrans` keeps `hreadyout`=1 with no APB activity.
